// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative radix-2 restoring divider for the RV32M divide
//               group (DIV, DIVU, REM, REMU). A request is taken on a
//               valid/ready port, one quotient bit is produced per cycle, and
//               the sign-corrected result is returned on a valid/ready
//               response port. RISC-V divide-by-zero and signed-overflow
//               results are produced without trapping.
// Ports       : clk_i, rst_i (async, active-high)
//               valid_i / ready_o                 request handshake
//               op_i, dividend_i, divisor_i       request payload
//               flush_i                           kill in-flight operation
//               valid_o / ready_i                 response handshake
//               result_o                          quotient or remainder
//               busy_o                            high in CALC or DONE
// Options     : DIV_SPECIAL_FAST_EN - when defined, divide by zero, signed
//               overflow and |divisor| > |dividend| bypass the iterations
//               (result after one cycle). Results are identical either way.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   dvsr;
    logic [XLEN-1:0]   result;
    logic [CNT_W-1:0]  cnt;
    logic              rem_sel;     // latched op_i[1]: 1 selects remainder
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic              accept;
    logic              is_signed;
    logic [XLEN-1:0]   dividend_mag;
    logic [XLEN-1:0]   divisor_mag;
    logic              divisor_zero;
    logic [XLEN-1:0]   quo_load;
    logic [XLEN-1:0]   rem_load;
    logic [CNT_W-1:0]  cnt_load;

    // A flush in IDLE suppresses a simultaneous request.
    assign accept       = valid_i && (state == IDLE) && !flush_i;
    assign is_signed    = ~op_i[0];
    assign dividend_mag = (is_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
    assign divisor_mag  = (is_signed && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
    assign divisor_zero = (divisor_i == '0);

`ifdef DIV_SPECIAL_FAST_EN
    logic signed_ovf;
    assign signed_ovf = is_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                        && (divisor_i == '1);

    // Short-circuit cases preload the final magnitudes and zero iterations,
    // so CALC falls through to DONE on the next edge.
    always_comb begin
        quo_load = dividend_mag;
        rem_load = '0;
        cnt_load = CNT_W'(XLEN);
        if (divisor_zero) begin
            quo_load = '1;
            rem_load = dividend_mag;
            cnt_load = '0;
        end else if (signed_ovf) begin
            // |MIN| / 1: quotient magnitude is the dividend, remainder 0.
            quo_load = dividend_mag;
            rem_load = '0;
            cnt_load = '0;
        end else if (divisor_mag > dividend_mag) begin
            quo_load = '0;
            rem_load = dividend_mag;
            cnt_load = '0;
        end
    end
`else
    assign quo_load = dividend_mag;
    assign rem_load = '0;
    assign cnt_load = CNT_W'(XLEN);
`endif

    // ------------------------------------------------------------------
    // One restoring step: trial subtract on XLEN+1 bits so the borrow
    // shows up as the sign bit.
    // ------------------------------------------------------------------
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     trial;
    logic              trial_ok;

    assign rem_shift = {rem, quo[XLEN-1]};
    assign trial     = rem_shift - {1'b0, dvsr};
    assign trial_ok  = ~trial[XLEN];

    // ------------------------------------------------------------------
    // Sign fix-up. Divide by zero must return all ones regardless of the
    // operand signs, so negation is masked there.
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result_fix;

    assign quo_fix    = div_zero ? '1 : (neg_q ? -quo : quo);
    assign rem_fix    = neg_r ? -rem : rem;
    assign result_fix = rem_sel ? rem_fix : quo_fix;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Flush wins over a concurrent handshake.
                if (flush_i || ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            quo      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            result   <= '0;
            cnt      <= '0;
            rem_sel  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            if (accept) begin
                rem_sel  <= op_i[1];
                neg_q    <= is_signed && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                neg_r    <= is_signed && dividend_i[XLEN-1];
                div_zero <= divisor_zero;
                dvsr     <= divisor_mag;
                quo      <= quo_load;
                rem      <= rem_load;
                cnt      <= cnt_load;
            end else if ((state == CALC) && !flush_i) begin
                if (cnt != '0) begin
                    if (trial_ok) begin
                        rem <= trial[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    // Entering DONE: register the corrected result.
                    result <= result_fix;
                end
            end
        end
    end

    assign ready_o  = (state == IDLE);
    assign valid_o  = (state == DONE);
    assign busy_o   = (state != IDLE);
    assign result_o = result;

endmodule
`default_nettype wire
